// File: rtl/alu_wide_op_sequencer.sv
// alu_wide_op_sequencer
//
// Runs a 32-bit ADD/SUB on a shared 16-bit ALU. Each operation takes three ALU cycles:
//   - PRESET loads the ALU carry flag.
//   - LOW runs ADC on the low halves.
//   - HIGH runs ADC on the high halves.
// The ALU's registered carry chains the halves. The 32-bit result and merged flags are then
// returned over a valid/ready handshake.
//
// Optional feature: define ALU_WIDE_CMP_EN to make ReqOp=10 a compare.
//   - A compare runs the SUB sequence.
//   - It reports zero as the result.
//   - It returns the SUB flags.
//
// Ports:
//   Clock, Reset             clock; synchronous active-low reset
//   ReqValid/ReqReady        request handshake
//   ReqOp                    request op: 00 ADD, 01 SUB, 10 CMP/ADD, 11 ADD
//   ReqA, ReqB               request operands
//   AluA, AluB               ALU operands
//   AluFunSel, AluWF         ALU function select and flag write enable
//   AluOut, AluFlags         ALU result and registered flags {Z,C,N,O}
//   RspValid/RspReady        response handshake
//   RspResult, RspFlags      response result and flags {Z,C,N,O}
// Note: the ALU flag register is left holding the high-half ADC flags.
module alu_wide_op_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  ReqOp,
    input  logic [31:0] ReqA,
    input  logic [31:0] ReqB,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [15:0] AluOut,
    input  logic [3:0]  AluFlags,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspResult,
    output logic [3:0]  RspFlags
);

    localparam logic [4:0] FunIdle = 5'b10000;
    localparam logic [4:0] FunLsl  = 5'b11011;
    localparam logic [4:0] FunAdc  = 5'b10101;

    typedef enum logic [2:0] {StIdle, StPreset, StLow, StHigh, StFlags, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;      // already inverted for SUB/CMP
    logic        sub_q, sub_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;
    logic        req_sub;

`ifdef ALU_WIDE_CMP_EN
    logic cmp_q, cmp_d;
    assign req_sub   = (ReqOp == 2'b01) || (ReqOp == 2'b10);
    // A compare keeps the difference internally for Z but reports zero.
    assign RspResult = cmp_q ? 32'd0 : res_q;
`else
    assign req_sub   = (ReqOp == 2'b01);
    assign RspResult = res_q;
`endif

    assign RspFlags = flags_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
`ifdef ALU_WIDE_CMP_EN
            cmp_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            flags_q <= flags_d;
`ifdef ALU_WIDE_CMP_EN
            cmp_q   <= cmp_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        res_d     = res_q;
        flags_d   = flags_q;
`ifdef ALU_WIDE_CMP_EN
        cmp_d     = cmp_q;
`endif
        ReqReady  = 1'b0;
        RspValid  = 1'b0;
        AluA      = 16'h0000;
        AluB      = 16'h0000;
        AluFunSel = FunIdle;
        AluWF     = 1'b0;

        unique case (state_q)
            StIdle: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    a_d     = ReqA;
                    b_d     = req_sub ? ~ReqB : ReqB;
                    sub_d   = req_sub;
`ifdef ALU_WIDE_CMP_EN
                    cmp_d   = (ReqOp == 2'b10);
`endif
                    state_d = StPreset;
                end
            end
            StPreset: begin
                // The shift moves AluA[15] into C, which gives the carry-in for the low ADC.
                AluFunSel = FunLsl;
                AluA      = sub_q ? 16'h8000 : 16'h0000;
                AluWF     = 1'b1;
                state_d   = StLow;
            end
            StLow: begin
                AluFunSel = FunAdc;
                AluA      = a_q[15:0];
                AluB      = b_q[15:0];
                AluWF     = 1'b1;
                res_d     = {res_q[31:16], AluOut};
                state_d   = StHigh;
            end
            StHigh: begin
                AluFunSel = FunAdc;
                AluA      = a_q[31:16];
                AluB      = b_q[31:16];
                AluWF     = 1'b1;
                res_d     = {AluOut, res_q[15:0]};
                state_d   = StFlags;
            end
            StFlags: begin
                // ALU Z only covers the high half, so Z is rebuilt from the full result.
                flags_d = {(res_q == 32'd0), AluFlags[2:0]};
                state_d = StResp;
            end
            StResp: begin
                RspValid = 1'b1;
                if (RspReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_wide_op_sequencer.sv
module tb_alu_wide_op_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [1:0]  ReqOp;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [15:0] AluOut;
    logic [3:0]  AluFlags;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspResult;
    logic [3:0]  RspFlags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    alu_wide_op_sequencer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqOp     (ReqOp),
        .ReqA      (ReqA),
        .ReqB      (ReqB),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluFunSel (AluFunSel),
        .AluWF     (AluWF),
        .AluOut    (AluOut),
        .AluFlags  (AluFlags),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspResult (RspResult),
        .RspFlags  (RspFlags)
    );

    // Stand-in for the shared 16-bit ALU: combinational result, registered flags {Z,C,N,O}.
    logic [3:0]  alu_flags_q = 4'b0000;
    logic [3:0]  alu_flags_n;
    logic [16:0] alu_sum;

    always_comb begin
        AluOut      = AluA;
        alu_flags_n = alu_flags_q;
        alu_sum     = 17'd0;
        case (AluFunSel)
            5'b11011: begin
                AluOut      = {AluA[14:0], 1'b0};
                alu_flags_n = {(AluOut == 16'd0), AluA[15], AluOut[15], 1'b0};
            end
            5'b10101: begin
                alu_sum     = {1'b0, AluA} + {1'b0, AluB} + {16'd0, alu_flags_q[2]};
                AluOut      = alu_sum[15:0];
                alu_flags_n = {(AluOut == 16'd0), alu_sum[16], AluOut[15],
                               (AluA[15] == AluB[15]) && (AluOut[15] != AluA[15])};
            end
            default: ;
        endcase
    end

    assign AluFlags = alu_flags_q;

    always @(posedge Clock) if (AluWF) alu_flags_q <= alu_flags_n;

    int wf_cnt = 0;
    always @(posedge Clock) if (AluWF) wf_cnt <= wf_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 32-bit two's complement arithmetic. Returns {Z,C,N,O, result}.
    function automatic logic [35:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] s;
        logic        sub;
        logic        cmp;
        logic [31:0] r;
        logic        o;
        sub = (op == 2'b01);
        cmp = 1'b0;
`ifdef ALU_WIDE_CMP_EN
        if (op == 2'b10) begin
            sub = 1'b1;
            cmp = 1'b1;
        end
`endif
        if (sub) s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else     s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        if (sub) o = (a[31] != b[31]) && (r[31] != a[31]);
        else     o = (a[31] == b[31]) && (r[31] != a[31]);
        return {(r == 32'd0), s[32], r[31], o, (cmp ? 32'd0 : r)};
    endfunction

    // Starts and ends at a negedge with the DUT idle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [35:0] e, input int hold, input bit noise);
        int n;
        int wf0;
        check("req_ready_idle", 32'(ReqReady), 32'd1);
        ReqValid = 1'b1;
        ReqOp    = op;
        ReqA     = a;
        ReqB     = b;
        RspReady = 1'b0;
        wf0      = wf_cnt;
        @(posedge Clock);
        @(negedge Clock);
        if (noise) begin
            ReqA  = $urandom;
            ReqB  = $urandom;
            ReqOp = 2'($urandom);
        end else begin
            ReqValid = 1'b0;
        end
        check("req_ready_busy", 32'(ReqReady), 32'd0);
        n = 0;
        while (!RspValid && n < 10) begin
            @(posedge Clock);
            n++;
            @(negedge Clock);
        end
        check("latency", n, 32'd4);
        check("wf_cycles", wf_cnt - wf0, 32'd3);
        for (int i = 0; i <= hold; i++) begin
            check("rsp_valid", 32'(RspValid), 32'd1);
            check("rsp_result", RspResult, e[31:0]);
            check("rsp_flags", 32'(RspFlags), 32'(e[35:32]));
            check("req_ready_resp", 32'(ReqReady), 32'd0);
            if (i < hold) begin
                @(posedge Clock);
                @(negedge Clock);
            end
        end
        RspReady = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        RspReady = 1'b0;
        ReqValid = 1'b0;
        check("rsp_valid_done", 32'(RspValid), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, 32'(ReqReady), 32'd1);
        check({tag, "_rsp_valid"}, 32'(RspValid), 32'd0);
        check({tag, "_rsp_result"}, RspResult, 32'd0);
        check({tag, "_rsp_flags"}, 32'(RspFlags), 32'd0);
        check({tag, "_alu_wf"}, 32'(AluWF), 32'd0);
        check({tag, "_alu_funsel"}, 32'(AluFunSel), 32'h10);
        check({tag, "_alu_ab"}, {AluA, AluB}, 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        Reset    = 1'b0;
        ReqValid = 1'b0;
        ReqOp    = 2'b00;
        ReqA     = '0;
        ReqB     = '0;
        RspReady = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_reset_state("reset");
        Reset = 1'b1;

        do_op(2'b00, 32'h0001FFFF, 32'h00000001, {4'b0000, 32'h00020000}, 0, 1'b0);
        do_op(2'b01, 32'h00010000, 32'h00000001, {4'b0100, 32'h0000FFFF}, 0, 1'b0);
        do_op(2'b01, 32'h00000000, 32'h00000001, {4'b0010, 32'hFFFFFFFF}, 0, 1'b0);
        do_op(2'b00, 32'h7FFFFFFF, 32'h00000001, {4'b0011, 32'h80000000}, 0, 1'b0);
        do_op(2'b00, 32'hFFFFFFFF, 32'h00000001, {4'b1100, 32'h00000000}, 3, 1'b1);
        do_op(2'b11, 32'h00001234, 32'h00001111, {4'b0000, 32'h00002345}, 0, 1'b0);
`ifdef ALU_WIDE_CMP_EN
        do_op(2'b10, 32'd5, 32'd5, {4'b1100, 32'd0}, 0, 1'b0);
`else
        do_op(2'b10, 32'd5, 32'd5, {4'b0000, 32'd10}, 0, 1'b0);
`endif

        // Reset while in HIGH: accept edge, then PRESET->LOW and LOW->HIGH edges.
        ReqValid = 1'b1;
        ReqOp    = 2'b00;
        ReqA     = 32'h12345678;
        ReqB     = 32'h11111111;
        @(posedge Clock);
        @(negedge Clock);
        ReqValid = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check_reset_state("midreset");
        Reset = 1'b1;
        do_op(2'b00, 32'd2, 32'd3, {4'b0000, 32'd5}, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = (k % 4 == 0) ? a : $urandom;
            do_op(op, a, b, ref_op(op, a, b), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_wide_op_sequencer.md
# alu_wide_op_sequencer

- Executes 32-bit ADD/SUB requests by driving the shared 16-bit ALU over three consecutive ALU cycles.
- Each cycle uses the ALU's registered carry flag to chain the halves.
- Sits directly upstream of the ALU and owns its A, B, FunSel and WF inputs while busy.
- Captures the 32-bit result and merged 32-bit flags, then hands them downstream over a valid/ready handshake.

## Interface
Parameters: none.

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- ReqValid  in  1  request valid
- ReqReady  out  1  sequencer can accept a request
- ReqOp  in  2  00 ADD, 01 SUB, 10 CMP (see Configuration), 11 reserved
- ReqA  in  32  operand A
- ReqB  in  32  operand B
- AluA  out  16  to ALU A
- AluB  out  16  to ALU B
- AluFunSel  out  5  to ALU FunSel
- AluWF  out  1  to ALU WF
- AluOut  in  16  ALU result, combinational
- AluFlags  in  4  ALU flags: [3]Z [2]C [1]N [0]O
- RspValid  out  1  result valid
- RspReady  in  1  downstream accepts result
- RspResult  out  32  32-bit result
- RspFlags  out  4  [3]Z [2]C [1]N [0]O for the 32-bit operation

## Operation
- Request latching: on a ReqValid & ReqReady edge, latch ReqA, ReqB and the op.
- SUB operand: for SUB, latch B as ~ReqB.
- States:
  - IDLE: ReqReady=1; AluFunSel=10000, AluA=AluB=0, AluWF=0. Handshake -> PRESET.
  - PRESET: AluFunSel=11011 (16-bit LSL), AluWF=1. AluA=16'h8000 for SUB/CMP, 16'h0000 for ADD. The ALU sets C=AluA[15], so carry-in is 1 for SUB and 0 for ADD. -> LOW.
  - LOW: AluFunSel=10101 (ADC), AluA=A[15:0], AluB=Bop[15:0], AluWF=1. Register AluOut into res[15:0] at the edge. -> HIGH.
  - HIGH: AluFunSel=10101, AluA=A[31:16], AluB=Bop[31:16], AluWF=1. Register AluOut into res[31:16]. -> FLAGS.
  - FLAGS: AluWF=0. Register RspFlags from AluFlags: C, N and O taken as-is from the high-half ADC; Z = (res==0). -> RESP.
  - RESP: RspValid=1, RspResult=res. On RspReady -> IDLE.
- Outputs stay stable while RspValid=1 and RspReady=0.
- Carry semantics: C is the raw carry-out of A + ~B + 1. For SUB, C=1 means no borrow.
- Overflow: O is the ALU's ADC overflow on the high half, which is correct signed overflow for both ADD and SUB because B is fed pre-inverted.
- ALU flag side effect: the ALU flag register is clobbered. It holds the high-half ADC flags after the operation, and the sequencer does not restore it.
- Reserved op: ReqOp=11 executes as ADD.

## Timing
- Reset values: ReqReady=1, RspValid=0, RspResult=0, RspFlags=0, AluWF=0, AluFunSel=10000, AluA=AluB=0; state IDLE.
- Latency: accept at edge N -> RspValid=1 after edge N+4. One request is in flight at a time.
- ReqReady: 0 from the accept edge until the response handshake edge. A new request is accepted no earlier than the edge after the response handshake.
- ALU ownership: AluWF is high in exactly three cycles per operation (PRESET, LOW, HIGH).
- Carry chaining: the ALU ADC reads its registered C, so each ADC sees the carry written at the preceding edge.
- Reset mid-operation: an edge with Reset=0 in any state forces IDLE and the reset values above. Partial results are discarded and the ALU flags are left as last written.
- Ignored inputs: ReqValid is ignored outside IDLE; RspReady is ignored outside RESP.

## Configuration
- ALU_WIDE_CMP_EN defined: ReqOp=10 (CMP) runs the SUB sequence. RspResult=0, RspFlags are the SUB flags, and Z is computed from the internal difference.
- ALU_WIDE_CMP_EN undefined: ReqOp=10 executes as ADD, and no CMP logic is present.

## Test plan
- ADD 0x0001FFFF + 0x00000001 -> RspResult=0x00020000, RspFlags=0000; RspValid rises exactly 4 edges after accept.
- SUB 0x00010000 - 0x00000001 -> 0x0000FFFF, flags Z0 C1 N0 O0. SUB 0x00000000 - 0x00000001 -> 0xFFFFFFFF, Z0 C0 N1 O0.
- ADD 0x7FFFFFFF + 1 -> 0x80000000, N1 O1 C0 Z0. ADD 0xFFFFFFFF + 1 -> 0x00000000, Z1 C1 N0 O0.
- Backpressure: hold RspReady=0 for 3 cycles -> RspValid, RspResult and RspFlags stable and ReqReady=0. A back-to-back request is accepted the cycle after the handshake.
- Reset=0 during HIGH -> next edge: IDLE, ReqReady=1, RspValid=0, RspResult=0. A following ADD 2+3 returns 5.
- With ALU_WIDE_CMP_EN: CMP 5,5 -> RspResult=0, Z1 C1. Without it: ReqOp=10 on 5,5 -> RspResult=10, Z0.
